tdm_demux_4ch: RTL

//  Receive end of the 4-channel time-division link; the transmit end selects one channel per beat.

---
 rtl/tdm_pkg.sv | 13 +
 rtl/tdm_slot_counter.sv | 39 +++
 rtl/tdm_demux_4ch.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM receive demultiplexer.
package tdm_pkg;

    localparam int unsigned NCH_DEF = 4;
    localparam int unsigned W_DEF   = 8;

    function automatic int unsigned slot_w(input int unsigned n);
        return $clog2(n);
    endfunction

    typedef enum logic {HUNT, LOCKED} tdm_state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter mod NCH; load0 marks the current beat as slot 0 so the next slot is 1.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEF,
    localparam int unsigned SW = slot_w(NCH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          inc_i,
    input  logic          load0_i,
    output logic [SW-1:0] slot_o,
    output logic          last_o
);

    logic [SW-1:0] slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (load0_i) begin
            slot_d = SW'(1);
        end else if (inc_i) begin
            // NCH is a power of two, so the natural wrap gives mod NCH
            slot_d = slot_q + SW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;
    assign last_o = (slot_q == SW'(NCH - 1));

endmodule

// File: rtl/tdm_demux_4ch.sv
// 4-channel TDM receive demultiplexer with frame_sync alignment and flywheel lock.
// Define TDM_DEMUX_DBUF_EN to publish whole frames from a shadow register.
module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int unsigned W        = W_DEF,
    parameter int unsigned NCH      = NCH_DEF,
    parameter int unsigned MISS_MAX = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [NCH*W-1:0] ch_data,
    output logic [NCH-1:0]   ch_valid,
    output logic             frame_done,
    output logic             sync_err,
    output logic             locked
);

    localparam int unsigned SW = slot_w(NCH);
    localparam int unsigned MW = $clog2(MISS_MAX + 1);

    tdm_state_t       state_q, state_d;
    logic [MW-1:0]    miss_q, miss_d;
    logic [NCH*W-1:0] ch_data_q, ch_data_d;
    logic [NCH-1:0]   ch_valid_q, ch_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             sync_err_q, sync_err_d;
    logic             inc, load0, last, cap_en;
    logic [SW-1:0]    slot, cap_slot;

    tdm_slot_counter #(
        .NCH (NCH)
    ) u_slot_counter (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (inc),
        .load0_i (load0),
        .slot_o  (slot),
        .last_o  (last)
    );

    always_comb begin
        state_d      = state_q;
        miss_d       = miss_q;
        inc          = 1'b0;
        load0        = 1'b0;
        cap_en       = 1'b0;
        cap_slot     = slot;
        sync_err_d   = 1'b0;
        frame_done_d = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        cap_en   = 1'b1;
                        cap_slot = '0;
                        load0    = 1'b1;
                        miss_d   = '0;
                        state_d  = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        sync_err_d = (slot != '0);
                        cap_en     = 1'b1;
                        cap_slot   = '0;
                        load0      = 1'b1;
                        miss_d     = '0;
                    end else if (slot == '0) begin
                        // Flywheel beat: too many missing syncs drops lock and discards the word
                        if (miss_q == MW'(MISS_MAX - 1)) begin
                            miss_d  = '0;
                            state_d = HUNT;
                        end else begin
                            miss_d = miss_q + MW'(1);
                            cap_en = 1'b1;
                            inc    = 1'b1;
                        end
                    end else begin
                        cap_en       = 1'b1;
                        inc          = 1'b1;
                        frame_done_d = last;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

`ifdef TDM_DEMUX_DBUF_EN
    logic [NCH*W-1:0] shd_q, shd_d;

    always_comb begin
        shd_d      = shd_q;
        ch_data_d  = ch_data_q;
        ch_valid_d = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            if (cap_en && cap_slot == SW'(k)) begin
                shd_d[k*W +: W] = din;
            end
        end
        if (frame_done_d) begin
            ch_data_d  = shd_d;
            ch_valid_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shd_q <= '0;
        end else begin
            shd_q <= shd_d;
        end
    end
`else
    always_comb begin
        ch_data_d  = ch_data_q;
        ch_valid_d = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            if (cap_en && cap_slot == SW'(k)) begin
                ch_data_d[k*W +: W] = din;
                ch_valid_d[k]       = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            miss_q       <= '0;
            ch_data_q    <= '0;
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            miss_q       <= miss_d;
            ch_data_q    <= ch_data_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign ch_data    = ch_data_q;
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = (state_q == LOCKED);

endmodule
